spi_reg_loader: RTL and testbench
=================================

SPI_REG_LOADER -- requirements
Module: spi_reg_loader

Interface
REQ-001 The block SHALL take one parameter: SYNC_STAGES, default 2, the number of synchronizer flops on each of SCK, MOSI and CS_N (legal 2..3).
REQ-002 The block SHALL have port CLK, input, 1 bit: the single system clock; all state changes on posedge CLK.
REQ-003 The block SHALL have port RST_N, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port SCK, input, 1 bit: external SPI clock (mode 0), asynchronous to CLK.
REQ-005 The block SHALL have port MOSI, input, 1 bit: serial data, MSB first, sampled on SCK rising edge.
REQ-006 The block SHALL have port CS_N, input, 1 bit: frame select, active-low.
REQ-007 The block SHALL have port PLD, output, [0:7]: parallel load data to the register bank; PLD[0] = first data bit received.
REQ-008 The block SHALL have port RSELIN, output, [0:1]: register select to the register bank; RSELIN[0] = first select bit received.
REQ-009 The block SHALL have port WSTB, output, 1 bit: one-CLK pulse marking a PLD/RSELIN update.
REQ-010 The block SHALL have port BUSY, output, 1 bit: high while a frame is in progress.
REQ-011 The block SHALL have port FRAME_ERR, output, 1 bit: one-CLK pulse on an aborted frame.

Function
REQ-012 SCK, MOSI and CS_N SHALL each pass through SYNC_STAGES flops; SCK rising edge SHALL be detected from the last two synchronized SCK samples.
REQ-013 A frame SHALL be 16 SCK rising edges while synchronized CS_N = 0: byte 0 = command, byte 1 = data, each MSB first.
REQ-014 Command byte: bit 7 = write flag; bits 1:0 = register select (bit 1 -> RSELIN[0], bit 0 -> RSELIN[1]); bits 6:2 ignored.
REQ-015 The FSM SHALL have states IDLE, CMD, DATA, HOLD.
REQ-016 IDLE -> CMD on synchronized CS_N falling; bit counter cleared to 0.
REQ-017 CMD: shift one bit per detected SCK edge; after the 8th bit, latch command, go to DATA.
REQ-018 DATA: shift one bit per edge; on the 8th bit, if write flag = 1, the next CLK edge SHALL load PLD and RSELIN together and assert WSTB for exactly one cycle; go to HOLD either way.
REQ-019 PLD and RSELIN SHALL change only together and only at the REQ-018 update; otherwise they hold their last value (the downstream bank reloads continuously, so partial values must never appear).
REQ-020 HOLD: further SCK edges ignored; -> IDLE on synchronized CS_N rising.
REQ-021 CS_N rising while in CMD or DATA SHALL abort: no PLD/RSELIN change, no WSTB, FRAME_ERR pulse for one cycle, -> IDLE.
REQ-022 CS_N rising on the same cycle as the 16th SCK edge SHALL count the edge first: the write completes, no FRAME_ERR.
REQ-023 BUSY SHALL be 1 in CMD, DATA, HOLD; 0 in IDLE.
REQ-024 Write flag = 0 frames SHALL complete silently (no WSTB, no error).
REQ-025 Timing contract: SCK high and low each >= SYNC_STAGES+1 CLK periods; faster SCK is out of spec.
REQ-026 Latency: WSTB SHALL assert SYNC_STAGES+2 CLK cycles after the 16th SCK rising edge at the pin, +/-1 cycle.

Reset
REQ-027 RST_N = 0 SHALL asynchronously force: PLD = 8'h00, RSELIN = 2'b00, WSTB = 0, BUSY = 0, FRAME_ERR = 0, state IDLE, shift register and counter 0, SCK syncs 0, CS_N syncs 1, MOSI syncs 0.
REQ-028 Reset asserted mid-frame SHALL discard the frame; after release, a frame SHALL be accepted only after a fresh CS_N falling edge.
REQ-029 Reset deassertion SHALL take effect on the next posedge CLK, with no spurious WSTB or FRAME_ERR.

Verification
REQ-030 Write: CS_N low, send 8'h82, 8'h5A -> one WSTB pulse; PLD = 8'h5A, RSELIN = 2'b10; BUSY falls after CS_N rises.
REQ-031 Read-flag frame: send 8'h03, 8'hFF -> no WSTB; PLD/RSELIN keep previous values; no FRAME_ERR.
REQ-032 Abort: CS_N rises after 11 bits of 8'h81, 8'hC3 -> FRAME_ERR one cycle, no WSTB, outputs unchanged; next full frame 8'h81, 8'h3C -> PLD = 8'h3C, RSELIN = 2'b01.
REQ-033 Overrun: 20 SCK edges in one frame 8'h80, 8'h11, then 4 extra -> single WSTB, PLD = 8'h11, RSELIN = 2'b00, extra bits ignored.
REQ-034 Reset mid-frame: RST_N low during DATA -> PLD = 8'h00, RSELIN = 2'b00, BUSY = 0 immediately; remaining SCK edges with CS_N still low -> no WSTB.
REQ-035 Back-to-back: two frames (8'h83, 8'hAA) then (8'h80, 8'h55) separated by a 1-SCK-period CS_N high gap -> two WSTB pulses; final PLD = 8'h55, RSELIN = 2'b00.

Source files
------------

// File: rtl/spi_reg_loader.sv
// Purpose : SPI mode-0 slave that receives a 16-bit frame {command, data} and loads an 8-bit register bank word.
// Latency : WSTB pulses SYNC_STAGES+2 CLK cycles after the 16th SCK rising edge at the pin.
// Backpressure: none; the SPI master owns the pace, and SCK must respect the minimum high/low time in CLK periods.
//
// Ports:
//   CLK, RST_N      system clock; asynchronous active-low reset
//   SCK, MOSI, CS_N SPI pins, asynchronous to CLK; MSB first, sampled on SCK rise, CS_N active-low
//   PLD[0:7]        parallel load data (PLD[0] = first data bit received)
//   RSELIN[0:1]     register select (RSELIN[0] = command bit 1)
//   WSTB            one-cycle strobe; PLD/RSELIN were just updated
//   BUSY            frame in progress (CMD, DATA or HOLD)
//   FRAME_ERR       one-cycle pulse when CS_N rises before the frame is complete

module spi_reg_loader #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       SCK,
  input  logic       MOSI,
  input  logic       CS_N,
  output logic [0:7] PLD,
  output logic [0:1] RSELIN,
  output logic       WSTB,
  output logic       BUSY,
  output logic       FRAME_ERR
);

  localparam int LAST = SYNC_STAGES - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    HOLD = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sync_fill;  // walks a 1 through; marks when the chains hold real pin samples
  logic                   sck_prev;
  logic                   cs_prev;
  logic                   cs_armed;   // a genuine CS_N high has been seen since reset

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sync_fill <= '0;
      sck_prev  <= 1'b0;
      cs_prev   <= 1'b1;
      cs_armed  <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS_N};
      sync_fill <= {sync_fill[SYNC_STAGES-2:0], 1'b1};
      sck_prev  <= sck_sync[LAST];
      cs_prev   <= cs_sync[LAST];
      // The CS_N chain resets to 1. If CS_N is still low at the pin when
      // reset is released, the chain drains from 1 to 0. That must not look
      // like a fresh frame start, so a falling edge only counts after a real
      // high level has travelled through the chain.
      if (sync_fill[LAST] && cs_sync[LAST]) begin
        cs_armed <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Edge detection on the synchronized samples
  // ---------------------------------------------------------------------------
  logic       sck_rise;
  logic       cs_fall;
  logic       cs_rise;
  logic       mosi_bit;

  assign sck_rise = sck_sync[LAST] & ~sck_prev;
  assign cs_fall  = cs_armed & cs_prev & ~cs_sync[LAST];
  assign cs_rise  = ~cs_prev & cs_sync[LAST];
  assign mosi_bit = mosi_sync[LAST];

  // ---------------------------------------------------------------------------
  // Frame FSM, shift register and output registers
  // ---------------------------------------------------------------------------
  state_t     state;
  logic [6:0] shreg;       // only 7 bits are stored; the 8th arrives live with the edge
  logic [2:0] bit_cnt;
  logic       wr_flag;
  logic [1:0] cmd_sel;
  logic       wr_pend;     // completed write waiting one cycle to be committed
  logic [7:0] pend_data;
  logic [1:0] pend_sel;

  logic [7:0] shift_next;
  logic       last_bit;

  assign shift_next = {shreg, mosi_bit};
  assign last_bit   = sck_rise && (bit_cnt == 3'd7);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      wr_flag   <= 1'b0;
      cmd_sel   <= '0;
      wr_pend   <= 1'b0;
      pend_data <= '0;
      pend_sel  <= '0;
      PLD       <= '0;
      RSELIN    <= '0;
      WSTB      <= 1'b0;
      BUSY      <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      WSTB      <= 1'b0;
      FRAME_ERR <= 1'b0;

      // PLD and RSELIN are only ever written here, and always together. The
      // bank downstream never sees a partial value.
      if (wr_pend) begin
        PLD     <= pend_data;
        RSELIN  <= pend_sel;
        WSTB    <= 1'b1;
        wr_pend <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (cs_fall) begin
            state   <= CMD;
            BUSY    <= 1'b1;
            bit_cnt <= '0;
            shreg   <= '0;
          end
        end

        CMD: begin
          if (cs_rise) begin
            state     <= IDLE;
            BUSY      <= 1'b0;
            FRAME_ERR <= 1'b1;
          end else if (sck_rise) begin
            shreg   <= shift_next[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              wr_flag <= shift_next[7];
              cmd_sel <= shift_next[1:0];
              state   <= DATA;
            end
          end
        end

        DATA: begin
          // The 16th edge wins over a simultaneous CS_N rise. In that case the
          // write still completes, and the state returns straight to IDLE
          // because the rise has already been consumed.
          if (last_bit) begin
            shreg   <= shift_next[6:0];
            bit_cnt <= '0;
            if (wr_flag) begin
              wr_pend   <= 1'b1;
              pend_data <= shift_next;
              pend_sel  <= cmd_sel;
            end
            if (cs_rise) begin
              state <= IDLE;
              BUSY  <= 1'b0;
            end else begin
              state <= HOLD;
            end
          end else if (cs_rise) begin
            state     <= IDLE;
            BUSY      <= 1'b0;
            FRAME_ERR <= 1'b1;
          end else if (sck_rise) begin
            shreg   <= shift_next[6:0];
            bit_cnt <= bit_cnt + 3'd1;
          end
        end

        HOLD: begin
          // Overrun SCK edges are ignored until the frame closes.
          if (cs_rise) begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_loader.sv
`timescale 1ns/1ps

module tb_spi_reg_loader;

  localparam int S = 2;

  logic       CLK;
  logic       RST_N;
  logic       SCK;
  logic       MOSI;
  logic       CS_N;
  logic [0:7] PLD;
  logic [0:1] RSELIN;
  logic       WSTB;
  logic       BUSY;
  logic       FRAME_ERR;

  spi_reg_loader #(.SYNC_STAGES(S)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .SCK       (SCK),
    .MOSI      (MOSI),
    .CS_N      (CS_N),
    .PLD       (PLD),
    .RSELIN    (RSELIN),
    .WSTB      (WSTB),
    .BUSY      (BUSY),
    .FRAME_ERR (FRAME_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [1:0]  sel;
    logic [7:0]  dat;
    int unsigned cyc;
  } exp_t;

  exp_t exp_q[$];
  int   exp_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the expected value is the last committed {sel, data}.
  // It only changes when the scoreboard retires an expected write.
  logic [1:0]  m_sel;
  logic [7:0]  m_pld;
  logic        prev_w;
  logic        prev_e;
  exp_t        e;
  int unsigned lat;

  always @(negedge CLK) begin
    if (!RST_N) begin
      m_sel  = 2'b00;
      m_pld  = 8'h00;
      prev_w = 1'b0;
      prev_e = 1'b0;
    end else begin
      if (WSTB) begin
        chk("wstb_width", {31'd0, prev_w}, 32'd0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_wstb: got PLD=%0h RSELIN=%0h expected no strobe", PLD, RSELIN);
        end else begin
          e = exp_q.pop_front();
          chk("wstb_data", {22'd0, RSELIN, PLD}, {22'd0, e.sel, e.dat});
          lat = cyc - e.cyc;
          chk("wstb_latency_ok", {31'd0, (lat >= S + 1) && (lat <= S + 3)}, 32'd1);
          m_sel = e.sel;
          m_pld = e.dat;
        end
      end else begin
        chk("outputs_hold", {22'd0, RSELIN, PLD}, {22'd0, m_sel, m_pld});
      end
      if (FRAME_ERR) begin
        chk("frame_err_width", {31'd0, prev_e}, 32'd0);
        if (exp_err == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_frame_err: got 1 expected 0");
        end else begin
          exp_err--;
        end
      end
      prev_w = WSTB;
      prev_e = FRAME_ERR;
    end
  end

  // Sends one frame. Bits past 16 are random filler. A write is expected only
  // when at least 16 bits arrive with command bit 7 set. Fewer than 16 bits
  // means an abort. cs_with_last raises CS_N together with the 16th SCK rise.
  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] dat, input int nbits,
                            input bit cs_with_last, input int half);
    logic [15:0] word;
    word = {cmd, dat};
    CS_N = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (i < 16) MOSI = word[15-i];
      else        MOSI = 1'($urandom_range(0, 1));
      #(half);
      if (i == nbits - 1) chk("busy_in_frame", {31'd0, BUSY}, 32'd1);
      SCK = 1'b1;
      if (i == 15) begin
        if (cmd[7]) exp_q.push_back('{sel: cmd[1:0], dat: dat, cyc: cyc});
        if (cs_with_last) CS_N = 1'b1;
      end
      #(half);
      SCK = 1'b0;
    end
    #(half);
    if (nbits < 16) exp_err++;
    CS_N = 1'b1;
    #(2 * half);
    chk("busy_after_frame", {31'd0, BUSY}, 32'd0);
  endtask

  task automatic spi_bit(input logic b, input int half);
    MOSI = b;
    #(half);
    SCK = 1'b1;
    #(half);
    SCK = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] cmd;
    logic [7:0] dat;
    logic [15:0] w;
    int nbits;
    int half;
    int r;
    bit cwl;

    RST_N = 1'b0;
    SCK   = 1'b0;
    MOSI  = 1'b0;
    CS_N  = 1'b1;
    #23;
    chk("reset_pld",       {24'd0, PLD},       32'h00);
    chk("reset_rselin",    {30'd0, RSELIN},    32'h0);
    chk("reset_wstb",      {31'd0, WSTB},      32'd0);
    chk("reset_busy",      {31'd0, BUSY},      32'd0);
    chk("reset_frame_err", {31'd0, FRAME_ERR}, 32'd0);
    #10 RST_N = 1'b1;
    #100;

    // Plain write
    send_frame(8'h82, 8'h5A, 16, 1'b0, 60);
    chk("write_pld",    {24'd0, PLD},    32'h5A);
    chk("write_rselin", {30'd0, RSELIN}, 32'h2);

    // Read flag: silent, values kept
    send_frame(8'h03, 8'hFF, 16, 1'b0, 60);
    chk("read_pld_kept",    {24'd0, PLD},    32'h5A);
    chk("read_rselin_kept", {30'd0, RSELIN}, 32'h2);

    // Abort after 11 bits, then a full frame
    send_frame(8'h81, 8'hC3, 11, 1'b0, 60);
    chk("abort_pld_kept", {24'd0, PLD}, 32'h5A);
    send_frame(8'h81, 8'h3C, 16, 1'b0, 60);
    chk("after_abort_pld",    {24'd0, PLD},    32'h3C);
    chk("after_abort_rselin", {30'd0, RSELIN}, 32'h1);

    // Overrun: 20 edges
    send_frame(8'h80, 8'h11, 20, 1'b0, 50);
    chk("overrun_pld",    {24'd0, PLD},    32'h11);
    chk("overrun_rselin", {30'd0, RSELIN}, 32'h0);

    // CS_N rising together with the 16th edge
    send_frame(8'h82, 8'hE7, 16, 1'b1, 60);
    chk("cs_last_pld", {24'd0, PLD}, 32'hE7);

    // Reset during DATA, then the rest of the frame with CS_N still low
    w = 16'h80F0;
    CS_N = 1'b0;
    for (int i = 0; i < 11; i++) spi_bit(w[15-i], 60);
    #30;
    RST_N = 1'b0;
    #1;
    chk("midrst_pld",    {24'd0, PLD},    32'h00);
    chk("midrst_rselin", {30'd0, RSELIN}, 32'h0);
    chk("midrst_busy",   {31'd0, BUSY},   32'd0);
    #29;
    RST_N = 1'b1;
    for (int i = 11; i < 16; i++) spi_bit(w[15-i], 60);
    #60;
    chk("midrst_busy_after", {31'd0, BUSY}, 32'd0);
    CS_N = 1'b1;
    #120;
    chk("midrst_pld_after", {24'd0, PLD}, 32'h00);

    // Back-to-back frames separated by one SCK period
    send_frame(8'h83, 8'hAA, 16, 1'b0, 50);
    send_frame(8'h80, 8'h55, 16, 1'b0, 50);
    #50;
    chk("b2b_pld",    {24'd0, PLD},    32'h55);
    chk("b2b_rselin", {30'd0, RSELIN}, 32'h0);

    // Random frames
    for (int k = 0; k < 40; k++) begin
      cmd = 8'($urandom);
      dat = 8'($urandom);
      r   = int'($urandom_range(0, 9));
      if (r < 6)      nbits = 16;
      else if (r < 8) nbits = int'($urandom_range(17, 24));
      else            nbits = int'($urandom_range(1, 15));
      cwl  = (nbits == 16) && ($urandom_range(0, 3) == 0);
      half = 10 * int'($urandom_range(5, 7));
      send_frame(cmd, dat, nbits, cwl, half);
    end

    #200;
    chk("queue_drained", exp_q.size(), 32'd0);
    chk("errors_drained", exp_err, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
